mul_seq_ctrl: RTL and testbench

- Multi-cycle sequencer for the multiply operation (ALU control code 4'b1100) of the single-cycle CPU.
- Accepts a decoded multiply request in the execute stage and stalls the PC/register-file write path while the multiply runs.
- Runs an iterative shift-add multiply and presents the low DATA_W bits of the product with a one-cycle done pulse.
- Every other ALU control code passes through untouched; this block ignores them.

---
 rtl/mul_seq_ctrl_pkg.sv | 22 ++
 rtl/mul_shift_add_dp.sv | 67 ++++++
 rtl/mul_seq_ctrl.sv | 113 +++++++++++
 tb/tb_mul_seq_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mul_seq_ctrl_pkg.sv
// Shared definitions for the multi-cycle multiply sequencer: ALU control
// codes, FSM state encoding and a small decode helper.
package mul_seq_ctrl_pkg;

  localparam logic [3:0] ALUCTRL_AND = 4'b0000;
  localparam logic [3:0] ALUCTRL_OR  = 4'b0001;
  localparam logic [3:0] ALUCTRL_ADD = 4'b0010;
  localparam logic [3:0] ALUCTRL_SUB = 4'b0110;
  localparam logic [3:0] ALUCTRL_SLT = 4'b0111;
  localparam logic [3:0] ALUCTRL_MUL = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic is_mul(input logic [3:0] ctrl);
    return (ctrl == ALUCTRL_MUL);
  endfunction

endpackage

// File: rtl/mul_shift_add_dp.sv
// Shift-add multiply datapath: operand/accumulator/iteration registers with
// load and step controls, reporting early-exit and last-iteration flags.
module mul_shift_add_dp
  import mul_seq_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  output logic              b_zero,
  output logic              cnt_last,
  output logic [DATA_W-1:0] acc_next
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [DATA_W-1:0] a_r;
  logic [DATA_W-1:0] b_r;
  logic [DATA_W-1:0] acc_r;
  logic [CNT_W-1:0]  cnt_r;

  // Accumulator value after the current step (wraps modulo 2^DATA_W)
  always_comb begin
    acc_next = acc_r;
    if (b_r[0]) begin
      acc_next = acc_r + a_r;
    end else begin
      acc_next = acc_r;
    end
  end

  // b_zero looks ahead: true when B becomes zero after this step's shift
  assign b_zero   = (b_r[DATA_W-1:1] == {(DATA_W-1){1'b0}});
  assign cnt_last = (cnt_r == CNT_LAST);

  // Operand, accumulator and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r   <= {DATA_W{1'b0}};
      b_r   <= {DATA_W{1'b0}};
      acc_r <= {DATA_W{1'b0}};
      cnt_r <= {CNT_W{1'b0}};
    end else if (load) begin
      a_r   <= src1;
      b_r   <= src2;
      acc_r <= {DATA_W{1'b0}};
      cnt_r <= {CNT_W{1'b0}};
    end else if (step) begin
      acc_r <= acc_next;
      a_r   <= {a_r[DATA_W-2:0], 1'b0};
      b_r   <= {1'b0, b_r[DATA_W-1:1]};
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      a_r   <= a_r;
      b_r   <= b_r;
      acc_r <= acc_r;
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/mul_seq_ctrl.sv
// Multi-cycle multiply sequencer: accepts ALU multiply requests, stalls the
// CPU while the shift-add datapath iterates, then pulses done with the result.
module mul_seq_ctrl
  import mul_seq_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [3:0]        ctrl_i,
  input  logic [DATA_W-1:0] src1_i,
  input  logic [DATA_W-1:0] src2_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] result_o
);

  state_t            state_r;
  logic              busy_r;
  logic              done_r;
  logic [DATA_W-1:0] result_r;

  logic              accept_s;
  logic              zero_op_s;
  logic              step_s;
  logic              b_zero_s;
  logic              cnt_last_s;
  logic [DATA_W-1:0] acc_next_s;

  assign accept_s  = (state_r == ST_IDLE) && start_i && is_mul(ctrl_i) && !flush_i;
  assign zero_op_s = (src1_i == {DATA_W{1'b0}}) || (src2_i == {DATA_W{1'b0}});
  assign step_s    = (state_r == ST_RUN) && !flush_i;

  // Stall is combinational so the CPU holds the PC in the accept cycle itself
  assign stall_o  = rst_i && !flush_i && (accept_s || (state_r == ST_RUN));
  assign busy_o   = busy_r;
  assign done_o   = done_r;
  assign result_o = result_r;

  mul_shift_add_dp #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_dp (
    .clk      (clk_i),
    .rst_n    (rst_i),
    .load     (accept_s),
    .step     (step_s),
    .src1     (src1_i),
    .src2     (src2_i),
    .b_zero   (b_zero_s),
    .cnt_last (cnt_last_s),
    .acc_next (acc_next_s)
  );

  // Sequencer FSM; busy/done/result are registered on the transition edge
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r  <= ST_IDLE;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      result_r <= {DATA_W{1'b0}};
    end else if (flush_i) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (accept_s && zero_op_s) begin
            state_r  <= ST_DONE;
            busy_r   <= 1'b0;
            done_r   <= 1'b1;
            result_r <= {DATA_W{1'b0}};
          end else if (accept_s) begin
            state_r <= ST_RUN;
            busy_r  <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (b_zero_s || cnt_last_s) begin
            state_r  <= ST_DONE;
            busy_r   <= 1'b0;
            done_r   <= 1'b1;
            result_r <= acc_next_s;
          end else begin
            state_r <= ST_RUN;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed self-checking bench for mul_seq_ctrl: products, zero fast path,
// flush/reset aborts, non-multiply pass-through and back-to-back issue.
module tb_mul_seq_ctrl;
  import mul_seq_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  ctrl;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        flush;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mul_seq_ctrl #(.DATA_W(32), .CNT_W(6)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (start),
    .ctrl_i   (ctrl),
    .src1_i   (src1),
    .src2_i   (src2),
    .flush_i  (flush),
    .stall_o  (stall),
    .busy_o   (busy),
    .done_o   (done),
    .result_o (result)
  );

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  // Issues one multiply in the current IDLE cycle and follows it to DONE
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                         output logic acc_stall, output int lat, output int runs,
                         output logic busy_seen, output logic done_stall,
                         output logic [31:0] res, output logic done_next,
                         output logic got_done);
    start = 1'b1; ctrl = ALUCTRL_MUL; src1 = a; src2 = b;
    #1;
    acc_stall = stall;
    next_cycle();
    start = 1'b0; src1 = 32'd0; src2 = 32'd0;
    lat = 0; runs = 0; busy_seen = 1'b0; got_done = 1'b0;
    done_stall = 1'b1; res = 32'hDEAD_BEEF; done_next = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      if (done) begin
        got_done = 1'b1; lat = i; res = result; done_stall = stall;
        break;
      end
      if (busy) busy_seen = 1'b1;
      if (busy && stall) runs++;
      next_cycle();
    end
    if (got_done) begin
      next_cycle();
      done_next = done;
    end
  endtask

  task automatic check_mul(input string name, input logic [31:0] a, input logic [31:0] b,
                           input int exp_runs, input logic [31:0] exp_res);
    logic acc_stall, busy_seen, done_stall, done_next, got_done;
    int lat, runs;
    logic [31:0] res;
    run_mul(a, b, acc_stall, lat, runs, busy_seen, done_stall, res, done_next, got_done);
    checks++;
    if (got_done !== 1'b1) begin errors++; $display("FAIL %s_done_timeout: got %0b expected 1", name, got_done); end
    checks++;
    if (acc_stall !== 1'b1) begin errors++; $display("FAIL %s_accept_stall: got %0b expected 1", name, acc_stall); end
    checks++;
    if (runs !== exp_runs) begin errors++; $display("FAIL %s_run_cycles: got %0d expected %0d", name, runs, exp_runs); end
    checks++;
    if (lat !== exp_runs + 1) begin errors++; $display("FAIL %s_latency: got %0d expected %0d", name, lat, exp_runs + 1); end
    checks++;
    if (res !== exp_res) begin errors++; $display("FAIL %s_result: got %08h expected %08h", name, res, exp_res); end
    checks++;
    if (done_stall !== 1'b0) begin errors++; $display("FAIL %s_done_stall: got %0b expected 0", name, done_stall); end
    checks++;
    if (done_next !== 1'b0) begin errors++; $display("FAIL %s_done_width: got %0b expected 0", name, done_next); end
    checks++;
    if (busy_seen !== (exp_runs > 0)) begin errors++; $display("FAIL %s_busy_seen: got %0b expected %0b", name, busy_seen, exp_runs > 0); end
  endtask

  task automatic test_reset;
    rst = 1'b0; start = 1'b1; ctrl = ALUCTRL_MUL; src1 = 32'd3; src2 = 32'd5; flush = 1'b0;
    #2;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0b expected 0", stall); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b expected 0", done); end
    checks++;
    if (result !== 32'd0) begin errors++; $display("FAIL reset_result: got %08h expected 00000000", result); end
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    next_cycle();
  endtask

  task automatic test_products;
    check_mul("mul_3x5", 32'd3, 32'd5, 3, 32'h0000_000F);
    check_mul("zero_fast", 32'h1234_5678, 32'd0, 0, 32'h0000_0000);
    check_mul("all_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32, 32'h0000_0001);
    check_mul("signed_neg7x6", 32'hFFFF_FFF9, 32'd6, 3, 32'hFFFF_FFD6);
  endtask

  task automatic test_flush;
    logic seen;
    start = 1'b1; ctrl = ALUCTRL_MUL; src1 = 32'd1; src2 = 32'h8000_0000;
    next_cycle();
    start = 1'b0;
    for (int i = 1; i < 10; i++) next_cycle();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL flush_pre_busy: got %0b expected 1", busy); end
    flush = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall_gate: got %0b expected 0", stall); end
    next_cycle();
    flush = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %0b expected 0", busy); end
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall: got %0b expected 0", stall); end
    checks++;
    if (result !== 32'hFFFF_FFD6) begin errors++; $display("FAIL flush_result_kept: got %08h expected ffffffd6", result); end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) seen = 1'b1;
      next_cycle();
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL flush_no_done: got %0b expected 0", seen); end
  endtask

  task automatic test_reset_mid;
    logic seen;
    start = 1'b1; ctrl = ALUCTRL_MUL; src1 = 32'd1; src2 = 32'h8000_0000;
    next_cycle();
    start = 1'b0;
    for (int i = 1; i < 5; i++) next_cycle();
    start = 1'b1;
    rst = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL rstmid_stall: got %0b expected 0", stall); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %0b expected 0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %0b expected 0", done); end
    checks++;
    if (result !== 32'd0) begin errors++; $display("FAIL rstmid_result: got %08h expected 00000000", result); end
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      next_cycle();
      if (done || busy) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL rstmid_quiet: got %0b expected 0", seen); end
  endtask

  task automatic test_nonmul;
    start = 1'b1; ctrl = ALUCTRL_ADD; src1 = 32'd7; src2 = 32'd9;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({stall, busy, done} !== 3'b000) begin
        errors++; $display("FAIL nonmul_idle: got %03b expected 000", {stall, busy, done});
      end
      next_cycle();
    end
    start = 1'b0;
  endtask

  task automatic test_back_to_back;
    check_mul("b2b_first_2x3", 32'd2, 32'd3, 2, 32'h0000_0006);
    check_mul("b2b_second_7x9", 32'd7, 32'd9, 4, 32'h0000_003F);
  endtask

  initial begin
    test_reset();
    test_products();
    test_flush();
    test_reset_mid();
    test_nonmul();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
